// File: rtl/prim_prince_arb.sv
// prim_prince_arb: round-robin arbiter and sequencer sharing a single prim_prince
// instance among NumReq requesters. A one-deep response register with valid/ready
// backpressure returns each result to the requester that issued it.
// Optional protocol checker: define PRIM_PRINCE_ARB_PROTO_CHECK_EN to drive err_o;
// without it err_o is tied low and no check logic is built.
module prim_prince_arb #(
  parameter int NumReq        = 2,
  parameter int DataWidth     = 64,
  parameter int CipherLatency = 0,
  parameter int IdxW          = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_dec_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [DataWidth-1:0]        rsp_data_o,
  output logic                        cipher_valid_o,
  output logic [DataWidth-1:0]        cipher_data_o,
  output logic                        cipher_dec_o,
  input  logic                        cipher_valid_i,
  input  logic [DataWidth-1:0]        cipher_data_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam bit Lat1 = (CipherLatency != 0);

  function automatic logic [IdxW-1:0] wrap_idx(input int v);
    return IdxW'(v % NumReq);
  endfunction

  logic                 inflight_q;
  logic [IdxW-1:0]      inflight_idx_q;
  logic                 rsp_valid_q;
  logic [IdxW-1:0]      rsp_idx_q;
  logic [DataWidth-1:0] rsp_data_q;
  logic [IdxW-1:0]      rr_ptr_q;

  logic                 gnt_found;
  logic [IdxW-1:0]      gnt_idx;
  logic [IdxW-1:0]      cand;
  logic                 rsp_pop;
  logic                 can_issue;
  logic                 issue;
  logic                 rsp_load;
  logic [IdxW-1:0]      rsp_load_idx;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 0; i < NumReq; i++) begin
      cand = wrap_idx(int'(rr_ptr_q) + i);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A new block may enter only when nothing is in flight and the response slot frees up.
  always_comb begin
    rsp_pop   = rsp_valid_q && rsp_ready_i[rsp_idx_q];
    can_issue = !inflight_q && (!rsp_valid_q || rsp_pop);
    issue     = can_issue && gnt_found;
  end

  // Grant decode and cipher input mux; the cipher inputs stay at zero when idle.
  always_comb begin
    req_ready_o   = '0;
    cipher_data_o = '0;
    cipher_dec_o  = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (issue && (gnt_idx == IdxW'(i))) begin
        req_ready_o[i] = 1'b1;
        cipher_data_o  = req_data_i[i*DataWidth +: DataWidth];
        cipher_dec_o   = req_dec_i[i];
      end
    end
  end

  assign cipher_valid_o = issue;

  // Result capture: same cycle as issue without a halfway register, else one cycle later.
  always_comb begin
    if (Lat1) begin
      rsp_load     = cipher_valid_i && inflight_q;
      rsp_load_idx = inflight_idx_q;
    end else begin
      rsp_load     = cipher_valid_i && issue;
      rsp_load_idx = gnt_idx;
    end
  end

  // Pointer, in-flight tracking and response register; a load overrides a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_idx_q      <= '0;
      rsp_data_q     <= '0;
    end else begin
      if (issue) begin
        rr_ptr_q <= wrap_idx(int'(gnt_idx) + 1);
      end
      if (Lat1) begin
        if (issue) begin
          inflight_q     <= 1'b1;
          inflight_idx_q <= gnt_idx;
        end else if (rsp_load) begin
          inflight_q     <= 1'b0;
        end
      end
      if (rsp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_idx_q   <= rsp_load_idx;
        rsp_data_q  <= cipher_data_i;
      end else if (rsp_pop) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Response valid is steered to the requester that owns the held result.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = rsp_valid_q && (rsp_idx_q == IdxW'(i));
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign busy_o     = inflight_q | rsp_valid_q;

`ifdef PRIM_PRINCE_ARB_PROTO_CHECK_EN
  logic [NumReq-1:0] vld_hist_q;
  logic              err_q;
  logic              err_set;

  // Violations: a pending request withdrawn, or cipher valid out of step with in-flight state.
  always_comb begin
    err_set = |(vld_hist_q & ~req_valid_i);
    if (Lat1) begin
      err_set = err_set | (cipher_valid_i && !inflight_q) | (inflight_q && !cipher_valid_i);
    end
  end

  // Remember which requesters were waiting unaccepted; latch any violation until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_hist_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_hist_q <= req_valid_i & ~req_ready_o;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_prince_arb.sv
// tb_prim_prince_arb: directed bench for prim_prince_arb with two instances,
// one per cipher latency. The cipher is a stand-in: the known PRINCE (key 0)
// pair 0 <-> 64'h818665aa0d02dfda, any other block XORed with a fixed mask.
module tb_prim_prince_arb;

  localparam logic [63:0] PRINCE_Z = 64'h818665aa0d02dfda;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] E0 = 64'hA486_1F3D_865B_3DE0;  // D0 ^ mask
  localparam logic [63:0] E1 = 64'h5B79_E0C2_79A4_C21F;  // D1 ^ mask

  logic clk;
  logic rst_n;

  logic [1:0]   rv0, rr0, rdec0, sv0, srdy0;
  logic [127:0] rd0;
  logic [63:0]  sd0, cd0o, cd0i;
  logic         cv0o, cdec0o, cv0i, busy0, err0;

  logic [1:0]   rv1, rr1, rdec1, sv1, srdy1;
  logic [127:0] rd1;
  logic [63:0]  sd1, cd1o, cd1i;
  logic         cv1o, cdec1o, cv1i, busy1, err1;

  logic         c1_v = 1'b0;
  logic [63:0]  c1_d = '0;
  logic         inj1;

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] model(input logic [63:0] d, input logic dec);
    if (!dec && d == 64'h0) return PRINCE_Z;
    if (dec && d == PRINCE_Z) return 64'h0;
    return d ^ 64'hA5A5_5A5A_0FF0_F00F;
  endfunction

  assign cv0i = cv0o;
  assign cd0i = model(cd0o, cdec0o);

  always @(posedge clk) begin
    c1_v <= cv1o;
    c1_d <= model(cd1o, cdec1o);
  end
  assign cv1i = c1_v | inj1;
  assign cd1i = c1_d;

  prim_prince_arb #(.NumReq(2), .DataWidth(64), .CipherLatency(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv0), .req_ready_o(rr0), .req_data_i(rd0), .req_dec_i(rdec0),
    .rsp_valid_o(sv0), .rsp_ready_i(srdy0), .rsp_data_o(sd0),
    .cipher_valid_o(cv0o), .cipher_data_o(cd0o), .cipher_dec_o(cdec0o),
    .cipher_valid_i(cv0i), .cipher_data_i(cd0i),
    .busy_o(busy0), .err_o(err0)
  );

  prim_prince_arb #(.NumReq(2), .DataWidth(64), .CipherLatency(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv1), .req_ready_o(rr1), .req_data_i(rd1), .req_dec_i(rdec1),
    .rsp_valid_o(sv1), .rsp_ready_i(srdy1), .rsp_data_o(sd1),
    .cipher_valid_o(cv1o), .cipher_data_o(cd1o), .cipher_dec_o(cdec1o),
    .cipher_valid_i(cv1i), .cipher_data_i(cd1i),
    .busy_o(busy1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; inj1 = 1'b0;
    rv0 = '0; rd0 = '0; rdec0 = '0; srdy0 = 2'b11;
    rv1 = '0; rd1 = '0; rdec1 = '0; srdy1 = 2'b11;
    #2;
    chk("rst_rdy0",  64'(rr0),   64'h0);
    chk("rst_rsp0",  64'(sv0),   64'h0);
    chk("rst_data0", sd0,        64'h0);
    chk("rst_cvld0", 64'(cv0o),  64'h0);
    chk("rst_busy0", 64'(busy0), 64'h0);
    chk("rst_err0",  64'(err0),  64'h0);
    chk("rst_rsp1",  64'(sv1),   64'h0);
    chk("rst_busy1", 64'(busy1), 64'h0);
    chk("rst_cvld1", 64'(cv1o),  64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request through the latency-1 instance
    step();
    rv1 = 2'b01; rd1 = '0; rdec1 = 2'b00; #1;
    chk("a_rdy",   64'(rr1),   64'h1);
    chk("a_cvld",  64'(cv1o),  64'h1);
    chk("a_busy",  64'(busy1), 64'h0);
    step();
    chk("a_rdy_inflight", 64'(rr1), 64'h0);
    chk("a_cvld_inflight", 64'(cv1o), 64'h0);
    chk("a_busy_inflight", 64'(busy1), 64'h1);
    chk("a_rsp_early", 64'(sv1), 64'h0);
    rv1 = 2'b00;
    step();
    chk("a_rsp",      64'(sv1),   64'h1);
    chk("a_rsp_data", sd1,        PRINCE_Z);
    chk("a_busy_rsp", 64'(busy1), 64'h1);
    step();
    chk("a_rsp_pop",  64'(sv1),   64'h0);
    chk("a_idle",     64'(busy1), 64'h0);

    // Fairness on the latency-0 instance
    step();
    rd0 = {D1, D0}; rv0 = 2'b11; rdec0 = 2'b00; #1;
    chk("b_g0",      64'(rr0), 64'h1);
    chk("b_g0_data", cd0o,     D0);
    step();
    chk("b_g1",      64'(rr0), 64'h2);
    chk("b_g1_data", cd0o,     D1);
    chk("b_r0",      64'(sv0), 64'h1);
    chk("b_r0_data", sd0,      E0);
    step();
    chk("b_g2",      64'(rr0), 64'h1);
    chk("b_r1",      64'(sv0), 64'h2);
    chk("b_r1_data", sd0,      E1);
    step();
    chk("b_g3",      64'(rr0), 64'h2);
    chk("b_r2",      64'(sv0), 64'h1);
    chk("b_r2_data", sd0,      E0);

    // Backpressure: response held, no grants
    srdy0 = 2'b00; #1;
    chk("c_blk_rdy",  64'(rr0),  64'h0);
    chk("c_blk_cvld", 64'(cv0o), 64'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("c_hold_vld",  64'(sv0), 64'h1);
      chk("c_hold_data", sd0,      E0);
      chk("c_hold_rdy",  64'(rr0), 64'h0);
    end
    srdy0 = 2'b01; #1;
    chk("c_release_rdy", 64'(rr0), 64'h2);
    step();
    chk("c_next_vld",  64'(sv0), 64'h2);
    chk("c_next_data", sd0,      E1);
    rv0 = 2'b00; srdy0 = 2'b11;
    step();
    chk("c_drain_vld",  64'(sv0),   64'h0);
    chk("c_drain_busy", 64'(busy0), 64'h0);

    // Decrypt round trip from requester 1
    rd0 = {PRINCE_Z, 64'h0}; rv0 = 2'b10; rdec0 = 2'b10; #1;
    chk("d_rdy",  64'(rr0),    64'h2);
    chk("d_cdec", 64'(cdec0o), 64'h1);
    chk("d_cdat", cd0o,        PRINCE_Z);
    step();
    chk("d_rsp",      64'(sv0),    64'h2);
    chk("d_rsp0_low", 64'(sv0[0]), 64'h0);
    chk("d_rsp_data", sd0,         64'h0);
    rv0 = 2'b11; rdec0 = 2'b00; #1;
    chk("d_ptr_wrap", 64'(rr0), 64'h1);
    step();
    rv0 = 2'b00;
    chk("d_wrap_rsp",  64'(sv0), 64'h1);
    chk("d_wrap_data", sd0,      PRINCE_Z);
    step();
    chk("d_wrap_pop", 64'(sv0), 64'h0);

    // Reset while the latency-1 instance has a block in flight
    rd1 = {D1, 64'h0}; rv1 = 2'b10; rdec1 = 2'b00; #1;
    chk("e_rdy", 64'(rr1), 64'h2);
    step();
    rv1 = 2'b00;
    chk("e_busy", 64'(busy1), 64'h1);
    rst_n = 1'b0; #1;
    chk("e_rst_rsp",  64'(sv1),   64'h0);
    chk("e_rst_busy", 64'(busy1), 64'h0);
    chk("e_rst_cvld", 64'(cv1o),  64'h0);
    chk("e_rst_data", sd1,        64'h0);
    #1 rst_n = 1'b1;
    step();
    chk("e_late_rsp",  64'(sv1),   64'h0);
    chk("e_late_busy", 64'(busy1), 64'h0);
    step();
    chk("e_late_rsp2", 64'(sv1), 64'h0);
    rd1 = {D1, 64'h0}; rv1 = 2'b01; #1;
    chk("e_new_rdy", 64'(rr1), 64'h1);
    step();
    rv1 = 2'b00;
    step();
    chk("e_new_rsp",  64'(sv1), 64'h1);
    chk("e_new_data", sd1,      PRINCE_Z);
    step();
    chk("e_new_pop", 64'(sv1), 64'h0);

`ifdef PRIM_PRINCE_ARB_PROTO_CHECK_EN
    // Spurious cipher valid while idle
    rst_n = 1'b0; #1;
    chk("f_err_rst", 64'(err1), 64'h0);
    rst_n = 1'b1;
    step();
    inj1 = 1'b1;
    step();
    inj1 = 1'b0;
    chk("f_err_set", 64'(err1), 64'h1);
    chk("f_no_rsp",  64'(sv1),  64'h0);
    step();
    chk("f_err_sticky", 64'(err1), 64'h1);
    rst_n = 1'b0; #1;
    chk("f_err_clr", 64'(err1), 64'h0);
    rst_n = 1'b1;
`else
    chk("f_err0_tied", 64'(err0), 64'h0);
    chk("f_err1_tied", 64'(err1), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prim_prince_arb.md
Name: prim_prince_arb

Overview:
- Round-robin arbiter and sequencer that shares one prim_prince instance among NumReq requesters, e.g. instruction-fetch and data-side scrambling.
- Each requester issues a valid/ready request carrying a data block and an encrypt/decrypt flag.
- The block grants one requester, drives the cipher, tracks the in-flight transaction, and routes the result back through a one-deep response register with valid/ready backpressure.
- The key is shared and comes straight from the key manager. It is not arbitrated.

Parameters:
- NumReq, 2, number of requesters (2..8).
- DataWidth, 64, cipher block width (64 or 32).
- CipherLatency, 0, latency of the attached prim_prince: 0 = no halfway register, 1 = HalfwayDataReg set.
- IdxW, $clog2(NumReq), requester index width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero
- req_data_i  in  NumReq*DataWidth  per-requester data block; slot i = bits [i*DataWidth +: DataWidth]
- req_dec_i  in  NumReq  per-requester decrypt flag
- rsp_valid_o  out  NumReq  response valid; one-hot or zero
- rsp_ready_i  in  NumReq  per-requester response accept
- rsp_data_o  out  DataWidth  response data, shared by all requesters
- cipher_valid_o  out  1  to prim_prince valid_i
- cipher_data_o  out  DataWidth  to prim_prince data_i
- cipher_dec_o  out  1  to prim_prince dec_i
- cipher_valid_i  in  1  from prim_prince valid_o
- cipher_data_i  in  DataWidth  from prim_prince data_o
- busy_o  out  1  transaction in flight or response pending
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, cipher_valid_o=0, busy_o=0, err_o=0, RR pointer=0, inflight_q=0.

State:
- inflight_q (1b), inflight_idx_q (IdxW).
- rsp_valid_q (1b), rsp_idx_q (IdxW), rsp_data_q.
- rr_ptr_q (IdxW).

Issue rule:
- can_issue = !inflight_q && (!rsp_valid_q || rsp_pop).
- rsp_pop = rsp_valid_q && rsp_ready_i[rsp_idx_q].
- Issue happens when can_issue && |req_valid_i.

Arbitration:
- Grant goes to the first requester with valid set, searching from rr_ptr_q upward and wrapping modulo NumReq.
- req_ready_o[g]=1 only for the granted index, only when can_issue; combinational.
- On issue, rr_ptr_q <= (g+1) mod NumReq, so the pointer wraps from NumReq-1 to 0.
- With no valid requester, the pointer holds.

Cipher drive:
- cipher_valid_o = issue.
- cipher_data_o and cipher_dec_o are muxed from slot g. They are zero when not issuing, so the cipher does not toggle when idle.

CipherLatency=0:
- The result is sampled in the issue cycle, with cipher_valid_i=cipher_valid_o.
- rsp_valid_q <= 1 on the next edge.
- inflight_q stays 0.
- Throughput: 1 block/cycle when the consumer is always ready.
- Latency: request accept to rsp_valid_o = 1 cycle.

CipherLatency=1:
- On issue, inflight_q <= 1 and inflight_idx_q <= g.
- On cipher_valid_i && inflight_q, the response register loads with idx = inflight_idx_q, and inflight_q <= 0.
- Throughput: 1 block / 2 cycles.
- Latency: accept to rsp_valid_o = 2 cycles.

Response register:
- rsp_valid_o[rsp_idx_q] = rsp_valid_q.
- rsp_data_o is held stable while valid and not popped.
- Load and pop in the same cycle: the load wins, and the new response is presented next cycle.
- Pop without load clears rsp_valid_q.

Simultaneous and back-to-back events:
- Multiple valid requesters: exactly one is granted. The others wait and must hold valid and data (AXI-style).
- A request must not be dropped. Data and dec are sampled only in the accept cycle.
- Back-to-back from one requester while another waits: the waiting requester wins next, so fairness is bounded by NumReq-1 grants.

Reset mid-operation:
- All state clears. An in-flight result that arrives after reset is ignored. cipher_valid_i with inflight_q=0 is discarded (latency 1).

busy_o = inflight_q | rsp_valid_q.

Optional Feature:
- Macro: PRIM_PRINCE_ARB_PROTO_CHECK_EN.
- Defined: err_o is set sticky (cleared only by reset) on any of:
  - cipher_valid_i=1 while inflight_q=0 (CipherLatency=1);
  - cipher_valid_i=0 one cycle after issue (CipherLatency=1);
  - a requester dropping req_valid_i before acceptance.
- Defined, check behaviour: a spurious cipher_valid_i is discarded regardless of the macro; err_o only reports it.
- Defined, implementation: one valid-history register per requester.
- Undefined: err_o is tied 0 and no check logic is present.

Test Plan:
- Single request: CipherLatency=1, key 0, UseOldKeySched=1, req_valid_i=2'b01, data 64'h0, dec 0 -> req_ready_o=2'b01 at cycle 0, cipher_valid_o=1 at cycle 0, rsp_valid_o=2'b01 at cycle 2, rsp_data_o=64'h818665aa0d02dfda.
- Fairness: both requesters valid continuously, rsp_ready_i=2'b11, CipherLatency=0 -> grants alternate 0,1,0,1. Each response index matches its grant. One response per cycle.
- Backpressure: rsp_ready_i=0 for 5 cycles with 3 queued requests -> exactly one response held with stable data, req_ready_o=0 throughout. Releasing ready pops it, and the next grant occurs in the same cycle.
- Decrypt round trip: requester 1 decrypts 64'h818665aa0d02dfda with key 0 -> rsp_data_o=64'h0 to requester 1 only. rsp_valid_o[0] stays 0.
- Reset mid-flight: assert rst_ni=0 the cycle after issue (CipherLatency=1) -> all outputs 0 immediately. After release, no response appears, and a new request completes normally.
- With PRIM_PRINCE_ARB_PROTO_CHECK_EN: force cipher_valid_i=1 while idle -> err_o=1 the next cycle, sticky until reset, and no rsp_valid_o.
